// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator: two line memories plus a 3-column shift window over a raster pixel stream.
// One clock from accepted pixel to its window; stalls (pix_valid=0) freeze all state and hold outputs.
module window3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a7,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] a6,
  output logic [DATA_W-1:0] a5,
  output logic [DATA_W-1:0] a4,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_valid
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  logic [DATA_W-1:0] line0_mem [IMG_W];
  logic [DATA_W-1:0] line1_mem [IMG_W];
  logic [DATA_W-1:0] line0_rd, line1_rd;

  logic [X_W-1:0] x_q, x_d, cur_x;
  logic [Y_W-1:0] y_q, y_d, cur_y;

  // Column registers, index 0 = oldest (left) column.
  logic [2:0][DATA_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;

  // Output window in port order a0,a1,a2,a7,ac,a3,a6,a5,a4.
  logic [8:0][DATA_W-1:0] win_q, win_d;
  logic [X_W-1:0]         out_x_q, out_x_d;
  logic [Y_W-1:0]         out_y_q, out_y_d;
  logic                   out_valid_q, out_valid_d;

  assign cur_x    = pix_sof ? '0 : x_q;
  assign cur_y    = pix_sof ? '0 : y_q;
  assign line0_rd = line0_mem[cur_x];
  assign line1_rd = line1_mem[cur_x];

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    win_d       = win_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_valid_d = 1'b0;
    if (pix_valid) begin
      top_d = {line1_rd, top_q[2], top_q[1]};
      mid_d = {line0_rd, mid_q[2], mid_q[1]};
      bot_d = {pix_in,   bot_q[2], bot_q[1]};

      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
      end else begin
        x_d = cur_x + X_W'(1);
        y_d = cur_y;
      end

      // Border pixels shift the window but never publish it.
      out_valid_d = (cur_x >= X_W'(2)) && (cur_y >= Y_W'(2));
      if (out_valid_d) begin
        win_d   = {bot_d[2], bot_d[1], bot_d[0],
                   mid_d[2], mid_d[1], mid_d[0],
                   top_d[2], top_d[1], top_d[0]};
        out_x_d = cur_x - X_W'(1);
        out_y_d = cur_y - Y_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      win_q       <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      win_q       <= win_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Line memories are never cleared; the y>=2 gate hides stale rows.
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      line1_mem[cur_x] <= line0_rd;
      line0_mem[cur_x] <= pix_in;
    end
  end

  assign a0        = win_q[0];
  assign a1        = win_q[1];
  assign a2        = win_q[2];
  assign a7        = win_q[3];
  assign ac        = win_q[4];
  assign a3        = win_q[5];
  assign a6        = win_q[6];
  assign a5        = win_q[7];
  assign a4        = win_q[8];
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Randomised bench for window3x3_gen on an 8x6 image against an image-array reference model.
module tb_window3x3_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] a0, a1, a2, a7, ac, a3, a6, a5, a4;
  logic [2:0] out_x;
  logic [2:0] out_y;
  logic       out_valid;

  window3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .X_W(3), .Y_W(3)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .a0(a0), .a1(a1), .a2(a2), .a7(a7), .ac(ac), .a3(a3), .a6(a6), .a5(a5), .a4(a4),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: image as accepted so far plus held output values.
  int mimg [H][W];
  int mx = 0, my = 0;
  int exp_w [9];
  int exp_x = 0, exp_y = 0;
  bit exp_vld = 0;

  int nvalid;
  int first_ac, last_ac, last_a4, last_x, last_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit vld, input bit sof, input int pix, input bit r);
    bit acc;
    int cx, cy;
    int obs [9];
    pix_valid = vld;
    pix_sof   = sof;
    pix_in    = pix[7:0];
    rst       = r;
    @(posedge clk);
    acc = vld && !r;
    if (r) begin
      mx = 0; my = 0; exp_vld = 0; exp_x = 0; exp_y = 0;
      foreach (exp_w[i]) exp_w[i] = 0;
    end else if (vld) begin
      cx = sof ? 0 : mx;
      cy = sof ? 0 : my;
      mimg[cy][cx] = pix & 255;
      exp_vld = (cx >= 2) && (cy >= 2);
      if (exp_vld) begin
        exp_w[0] = mimg[cy-2][cx-2]; exp_w[1] = mimg[cy-2][cx-1]; exp_w[2] = mimg[cy-2][cx];
        exp_w[3] = mimg[cy-1][cx-2]; exp_w[4] = mimg[cy-1][cx-1]; exp_w[5] = mimg[cy-1][cx];
        exp_w[6] = mimg[cy][cx-2];   exp_w[7] = mimg[cy][cx-1];   exp_w[8] = mimg[cy][cx];
        exp_x = cx - 1;
        exp_y = cy - 1;
      end
      mx = (cx + 1) % W;
      my = (cx == W - 1) ? (cy + 1) % H : cy;
    end else begin
      exp_vld = 0;
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    if (exp_vld || !acc) begin
      obs = '{a0, a1, a2, a7, ac, a3, a6, a5, a4};
      foreach (obs[i]) check($sformatf("win[%0d]", i), obs[i], exp_w[i]);
      check("out_x", {29'd0, out_x}, exp_x);
      check("out_y", {29'd0, out_y}, exp_y);
    end
    if (out_valid) begin
      nvalid++;
      if (first_ac < 0) first_ac = ac;
      last_ac = ac; last_a4 = a4; last_x = out_x; last_y = out_y;
    end
  endtask

  // mode 0: constant 125, mode 1: ramp 16*y+x, mode 2: random
  task automatic send_frame(input int mode, input bit sof_first, input int stall_pct);
    int fp [H][W];
    nvalid = 0;
    first_ac = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        fp[y][x] = (mode == 0) ? 125 : (mode == 1) ? 16 * y + x : int'($urandom_range(255));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        while (int'($urandom_range(99)) < stall_pct)
          step(0, bit'($urandom_range(1)), int'($urandom_range(255)), 0);
        step(1, sof_first && x == 0 && y == 0, fp[y][x], 0);
      end
    end
    step(0, 0, 0, 0);
    check("nwin", nvalid, (W - 2) * (H - 2));
    check("first_ac", first_ac, fp[1][1]);
    if (mode == 1) begin
      check("last_x", last_x, 6);
      check("last_y", last_y, 4);
      check("last_ac", last_ac, 70);
      check("last_a4", last_a4, 87);
    end
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) step(1, i == 0, int'($urandom_range(255)), 0);
  endtask

  initial begin
    foreach (exp_w[i]) exp_w[i] = 0;
    step(0, 0, 0, 1);
    step(1, 1, 77, 1);
    send_frame(0, 1, 0);
    send_frame(1, 1, 0);
    send_frame(1, 1, 50);
    send_frame(2, 1, 0);
    send_frame(2, 0, 20);
    send_pixels(27);
    send_frame(2, 1, 0);
    send_pixels(29);
    step(1, 1, 200, 1);
    send_frame(1, 1, 30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
